// File: rtl/abs_value_pkg.sv
// Shared constants, mode enum and boundary-value helpers for the abs_value_pipe slice.
package abs_value_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_LANES = 4;

    typedef enum logic {
        ABS_WRAP = 1'b0,
        ABS_SAT  = 1'b1
    } abs_mode_e;

    // Results are 64 bits wide; callers keep the low WIDTH bits.
    function automatic logic [63:0] min_neg(input int unsigned width);
        logic [63:0] r;
        r = 64'd1 << (width - 1);
        return r;
    endfunction

    function automatic logic [63:0] max_pos(input int unsigned width);
        logic [63:0] r;
        r = (64'd1 << (width - 1)) - 64'd1;
        return r;
    endfunction

endpackage

// File: rtl/abs_value_lane.sv
// One lane: combinational magnitude/overflow plus the peak-magnitude hold register.
module abs_value_lane
    import abs_value_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  abs_mode_e        mode,
    input  logic             load,
    input  logic             clr,
    output logic [WIDTH-1:0] mag,
    output logic             ovf,
    output logic [WIDTH-1:0] peak
);

    localparam logic [63:0]      MIN_NEG_FULL = min_neg(WIDTH);
    localparam logic [63:0]      MAX_POS_FULL = max_pos(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG      = MIN_NEG_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MAX_POS      = MAX_POS_FULL[WIDTH-1:0];

    logic [WIDTH-1:0] peak_q, peak_d;

    always_comb begin
        mag = x;
        ovf = 1'b0;
        if (x == MIN_NEG) begin
            ovf = 1'b1;
            mag = (mode == ABS_SAT) ? MAX_POS : MIN_NEG;
        end else if (x[WIDTH-1]) begin
            mag = '0 - x;
        end
    end

    // A clear that coincides with a load restarts the peak from that beat.
    always_comb begin
        peak_d = peak_q;
        if (clr) begin
            peak_d = load ? mag : '0;
        end else if (load && (mag > peak_q)) begin
            peak_d = mag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak = peak_q;

endmodule

// File: rtl/abs_value_pipe.sv
// Registered multi-lane absolute value with valid/ready, wrap/saturate mode and peak hold.
module abs_value_pipe
    import abs_value_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned LANES = DEFAULT_LANES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sat_en,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_ovf,
    input  logic                   peak_clr,
    output logic [LANES*WIDTH-1:0] peak_abs,
    output logic                   ovf_sticky
);

    logic                   out_valid_q, out_valid_d;
    logic [LANES*WIDTH-1:0] out_data_q, out_data_d;
    logic [LANES-1:0]       out_ovf_q, out_ovf_d;
    logic                   ovf_sticky_q, ovf_sticky_d;

    logic                   in_fire, out_fire;
    logic [LANES*WIDTH-1:0] mag_all;
    logic [LANES-1:0]       ovf_all;
    abs_mode_e              mode;

    assign mode     = sat_en ? ABS_SAT : ABS_WRAP;
    assign in_ready = !out_valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        abs_value_lane #(
            .WIDTH(WIDTH)
        ) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .x    (in_data[i*WIDTH +: WIDTH]),
            .mode (mode),
            .load (in_fire),
            .clr  (peak_clr),
            .mag  (mag_all[i*WIDTH +: WIDTH]),
            .ovf  (ovf_all[i]),
            .peak (peak_abs[i*WIDTH +: WIDTH])
        );
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_ovf_d    = out_ovf_q;
        ovf_sticky_d = ovf_sticky_q;
        if (in_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = mag_all;
            out_ovf_d   = ovf_all;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
        if (peak_clr) begin
            ovf_sticky_d = in_fire && (|ovf_all);
        end else if (in_fire) begin
            ovf_sticky_d = ovf_sticky_q || (|ovf_all);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_ovf_q    <= '0;
            ovf_sticky_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_ovf_q    <= out_ovf_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_ovf    = out_ovf_q;
    assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_abs_value_pipe.sv
// Directed and random checks of abs_value_pipe (WIDTH=8, LANES=4) against a scoreboard model.
module tb_abs_value_pipe;

    logic        clk;
    logic        rst_n;
    logic        sat_en;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_ovf;
    logic        peak_clr;
    logic [31:0] peak_abs;
    logic        ovf_sticky;

    abs_value_pipe #(
        .WIDTH(8),
        .LANES(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sat_en    (sat_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .peak_clr  (peak_clr),
        .peak_abs  (peak_abs),
        .ovf_sticky(ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  o;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic        m_valid;
    logic [31:0] m_peak;
    logic        m_sticky;
    int          beats_in;
    int          beats_out;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference magnitude of one signed byte: {ovf, magnitude}.
    function automatic logic [8:0] ref_abs(input logic [7:0] x, input logic sat);
        int v;
        v = int'($signed(x));
        if (v == -128) return {1'b1, (sat ? 8'h7F : 8'h80)};
        if (v < 0) return {1'b0, 8'(-v)};
        return {1'b0, 8'(v)};
    endfunction

    task automatic model_reset();
        sb.delete();
        m_valid  = 1'b0;
        m_peak   = '0;
        m_sticky = 1'b0;
    endtask

    // One clock: pre-edge handshake/output checks, model update, post-edge state checks.
    task automatic cycle();
        logic        m_rdy, in_fire, out_fire;
        logic [31:0] md;
        logic [3:0]  mo;
        logic [8:0]  r;
        exp_t        e;
        #2;
        m_rdy = !m_valid || out_ready;
        chk("in_ready", 64'(in_ready), 64'(m_rdy));
        if (m_valid && sb.size() > 0) begin
            chk("out_data", 64'(out_data), 64'(sb[0].d));
            chk("out_ovf", 64'(out_ovf), 64'(sb[0].o));
        end
        in_fire  = in_valid && m_rdy;
        out_fire = m_valid && out_ready;
        if (out_fire && sb.size() > 0) begin
            void'(sb.pop_front());
            beats_out++;
        end
        md = '0;
        mo = '0;
        if (in_fire) begin
            for (int i = 0; i < 4; i++) begin
                r = ref_abs(in_data[i*8 +: 8], sat_en);
                md[i*8 +: 8] = r[7:0];
                mo[i] = r[8];
            end
            e.d = md;
            e.o = mo;
            sb.push_back(e);
            beats_in++;
        end
        for (int i = 0; i < 4; i++) begin
            if (peak_clr) m_peak[i*8 +: 8] = in_fire ? md[i*8 +: 8] : 8'h00;
            else if (in_fire && md[i*8 +: 8] > m_peak[i*8 +: 8]) m_peak[i*8 +: 8] = md[i*8 +: 8];
        end
        if (peak_clr) m_sticky = in_fire && (|mo);
        else if (in_fire) m_sticky = m_sticky || (|mo);
        if (in_fire) m_valid = 1'b1;
        else if (out_fire) m_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("peak_abs", 64'(peak_abs), 64'(m_peak));
        chk("ovf_sticky", 64'(ovf_sticky), 64'(m_sticky));
    endtask

    task automatic idle();
        in_valid = 1'b0;
        peak_clr = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] rd;
        int          cyc;

        rst_n = 1'b0;
        sat_en = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        peak_clr = 1'b0;
        beats_in = 0;
        beats_out = 0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_ovf", 64'(out_ovf), 64'd0);
        chk("rst_peak_abs", 64'(peak_abs), 64'd0);
        chk("rst_ovf_sticky", 64'(ovf_sticky), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Basic, saturate mode
        sat_en = 1'b1; in_valid = 1'b1; in_data = 32'h7F00FB05;
        cycle();
        idle();
        chk("basic_data", 64'(out_data), 64'h7F000505);
        chk("basic_ovf", 64'(out_ovf), 64'd0);
        cycle();

        // Most-negative value, saturate then wrap
        sat_en = 1'b1; in_valid = 1'b1; in_data = 32'h00800000;
        cycle();
        idle();
        chk("minneg_sat_data", 64'(out_data), 64'h007F0000);
        chk("minneg_sat_ovf", 64'(out_ovf), 64'b0100);
        chk("minneg_sat_sticky", 64'(ovf_sticky), 64'd1);
        sat_en = 1'b0; in_valid = 1'b1; in_data = 32'h00800000;
        cycle();
        idle();
        sat_en = 1'b1;
        chk("minneg_wrap_data", 64'(out_data), 64'h00800000);
        chk("minneg_wrap_ovf", 64'(out_ovf), 64'b0100);
        cycle();

        // Backpressure: two beats, output stalled for 5 cycles
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h01020304;
        cycle();
        in_data = 32'hFFFEFDFC;
        held = out_data;
        repeat (5) begin
            cycle();
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            chk("bp_data_stable", 64'(out_data), 64'(held));
        end
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("bp_second_beat", 64'(out_data), 64'h01020304);
        chk("bp_second_valid", 64'(out_valid), 64'd1);
        cycle();
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Peak hold on lane 0
        idle(); peak_clr = 1'b1;
        cycle();
        peak_clr = 1'b0; in_valid = 1'b1;
        in_data = 32'h00000010; cycle();
        in_data = 32'h000000E0; cycle();
        in_data = 32'h00000005; cycle();
        in_valid = 1'b0;
        chk("peak_lane0", 64'(peak_abs[7:0]), 64'h20);
        in_valid = 1'b1; peak_clr = 1'b1; in_data = 32'h00000003;
        cycle();
        chk("peak_clr_load", 64'(peak_abs[7:0]), 64'h03);
        in_valid = 1'b0; peak_clr = 1'b1;
        cycle();
        chk("peak_clr_only", 64'(peak_abs[7:0]), 64'h00);
        idle();
        cycle();

        // Random streaming
        beats_in = 0;
        beats_out = 0;
        cyc = 0;
        while (beats_in < 256 && cyc < 4000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            sat_en = $urandom_range(0, 1) == 1;
            peak_clr = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < 4; i++) begin
                rd[i*8 +: 8] = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
            end
            in_data = rd;
            cycle();
            cyc++;
        end
        chk("stream_beats_in", 64'(beats_in), 64'd256);
        idle();
        cyc = 0;
        while (m_valid && cyc < 20) begin
            cycle();
            cyc++;
        end
        chk("stream_order", 64'(beats_out), 64'(beats_in));
        chk("stream_sb_empty", 64'(sb.size()), 64'd0);

        // Reset while a beat is held
        out_ready = 1'b0; in_valid = 1'b1; sat_en = 1'b0; in_data = 32'h80808080;
        cycle();
        in_valid = 1'b0;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", 64'(out_data), 64'd0);
        chk("mid_rst_ovf", 64'(out_ovf), 64'd0);
        chk("mid_rst_peak", 64'(peak_abs), 64'd0);
        chk("mid_rst_sticky", 64'(ovf_sticky), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; sat_en = 1'b1; in_data = 32'h0000007E;
        cycle();
        idle();
        chk("post_rst_latency", 64'(out_valid), 64'd1);
        chk("post_rst_data", 64'(out_data), 64'h0000007E);
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/abs_value_pipe.md
# abs_value_pipe

Registered, multi-lane absolute-value unit with valid/ready flow control, selectable wrap/saturate handling of the most-negative input, per-lane overflow flags and per-lane peak-magnitude hold. It is the pipelined, parametrised successor to the team's single-lane combinational absolute-value block. It sits in the datapath between a signed sample source and downstream magnitude consumers such as level meters and threshold detectors.

## Interface
- WIDTH, 8: bits per lane; signed two's-complement input, unsigned magnitude output; legal range ≥ 2.
- LANES, 4: number of independent lanes processed per beat; legal range ≥ 1.
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- sat_en  input  1  mode select, sampled per accepted beat: 1 = saturate, 0 = wrap.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  LANES*WIDTH  signed samples; lane i occupies bits [i*WIDTH +: WIDTH].
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  LANES*WIDTH  unsigned magnitudes, same lane packing as in_data.
- out_ovf  output  LANES  per-lane flag: this beat's input was the most-negative value.
- peak_clr  input  1  synchronous clear of peak_abs and ovf_sticky.
- peak_abs  output  LANES*WIDTH  per-lane largest magnitude accepted since the last clear or reset.
- ovf_sticky  output  1  OR of out_ovf over all beats accepted since the last clear or reset.

## Operation
- Transfer rules: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- in_ready = !out_valid || out_ready. There is a single output register, full throughput, and no combinational path from in_valid to out_valid.
- On an input transfer, each lane x is loaded into the output register as follows:
  - x ≥ 0 gives x.
  - x < 0 and x ≠ MIN_NEG gives −x.
  - x = MIN_NEG (1 followed by WIDTH−1 zeros) sets out_ovf[i]=1. The magnitude is then:
    - sat_en=1: MAX_POS (0 followed by WIDTH−1 ones).
    - sat_en=0: 1 followed by WIDTH−1 zeros, i.e. the exact magnitude 2^(WIDTH−1) read as unsigned.
- All magnitude compares are unsigned, WIDTH bits. No lane ever carries into another lane.
- out_valid behaviour:
  - Set by an input transfer.
  - Cleared by an output transfer with no simultaneous input transfer.
  - Held, with out_data stable, while out_valid && !out_ready.
- Peak and sticky overflow:
  - On an input transfer, peak_abs[i] becomes max(peak_abs[i], new magnitude[i]).
  - ovf_sticky |= |new out_ovf.
- peak_clr with no input transfer: peak_abs and ovf_sticky clear to 0.
- peak_clr coinciding with an input transfer: peak_abs loads that beat's magnitudes and ovf_sticky loads that beat's OR-reduced out_ovf. The beat is never lost.
- peak_clr does not affect out_valid or out_data.

## Timing
- Latency: 1 cycle from input transfer to out_valid, and to the updated peak_abs and ovf_sticky.
- Reset values: out_valid=0, out_data=0, out_ovf=0, peak_abs=0, ovf_sticky=0; in_ready=1 while rst_n is high after reset.
- Reset asserted mid-beat discards any held output immediately and asynchronously. No beat is replayed.
- sat_en changes affect only beats accepted after the change, never a beat already held in the output register.

## Structure
- Shared package abs_value_pkg holds:
  - Default WIDTH and LANES constants.
  - Functions min_neg(WIDTH) and max_pos(WIDTH).
  - A typedef for the mode enum ABS_WRAP / ABS_SAT.
- One natural sub-module, abs_value_lane, instantiated LANES times via generate. Per lane it contains:
  - Combinational magnitude and ovf logic.
  - The peak_abs[i] register with clear/load priority.
- Top level owns the shared valid/ready register, out_valid, the out_data/out_ovf registers and ovf_sticky.

## Test plan
All scenarios use WIDTH=8, LANES=4.
- Basic, sat_en=1: in_data lanes {0x05, 0xFB, 0x00, 0x7F} → one cycle later out_data {0x05, 0x05, 0x00, 0x7F}, out_ovf=0000.
- Min-negative: lane 2 = 0x80, other lanes 0x00.
  - sat_en=1 gives lane 2 = 0x7F, out_ovf=0100, ovf_sticky=1.
  - sat_en=0 gives lane 2 = 0x80, out_ovf=0100.
- Backpressure: out_ready=0 for 5 cycles with in_valid held high.
  - in_ready=0 after the first beat and out_data stays stable.
  - The second beat appears exactly one cycle after out_ready rises. No beat is dropped or duplicated.
- Peak hold: lane 0 sequence 0x10, 0xE0, 0x05 gives peak_abs lane 0 = 0x20.
  - peak_clr coincident with an accepted 0x03 gives peak_abs lane 0 = 0x03.
  - peak_clr alone gives 0x00.
- Streaming: 256 random beats with random out_ready, checked against a scoreboard model for order, values, peak_abs and ovf_sticky.
- Reset mid-stream: drop rst_n while out_valid=1 → all outputs 0 in the same cycle; after release in_ready=1 and the next beat's latency is 1 cycle.
